ibpl_input_conditioner: RTL and testbench

Per-channel input conditioning stage for interbackplane cardlets. It takes the polarity-corrected `internal_in` vector produced by a cardlet plugin and synchronises it to `clk_sys`. It then debounces each channel and emits rise/fall strobes plus a pulse-stretched `input_act` vector that drives the cardlet activity LEDs. It sits directly downstream of the cardlet plugin and upstream of the blackbox input logic.

---
 rtl/ibpl_input_conditioner.sv | 95 +++++++++
 tb/tb_ibpl_input_conditioner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ibpl_input_conditioner.sv
// Per-channel input conditioning: two-flop synchroniser, debounce filter,
// registered rise/fall strobes and a pulse-stretched activity indication.
module ibpl_input_conditioner #(
  parameter int unsigned CHANNELS  = 6,
  parameter int unsigned DEB_W     = 8,
  parameter int unsigned STRETCH_W = 20
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic [CHANNELS-1:0] internal_in,
  input  logic [CHANNELS-1:0] input_enable,
  input  logic [DEB_W-1:0]    debounce_len,
  output logic [CHANNELS-1:0] in_filtered,
  output logic [CHANNELS-1:0] rise_strb,
  output logic [CHANNELS-1:0] fall_strb,
  output logic [CHANNELS-1:0] input_act
);

  logic [CHANNELS-1:0]  s1_q, s2_q;
  logic [CHANNELS-1:0]  filt_q, filt_d;
  logic [CHANNELS-1:0]  rise_q, rise_d;
  logic [CHANNELS-1:0]  fall_q, fall_d;
  logic [DEB_W-1:0]     cnt_q [CHANNELS];
  logic [DEB_W-1:0]     cnt_d [CHANNELS];
  logic [STRETCH_W-1:0] act_q [CHANNELS];
  logic [STRETCH_W-1:0] act_d [CHANNELS];

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      filt_d[i] = filt_q[i];
      rise_d[i] = 1'b0;
      fall_d[i] = 1'b0;
      act_d[i]  = act_q[i];
      if (!input_enable[i]) begin
        // A disabled channel drops its level silently, without a fall strobe.
        cnt_d[i]  = '0;
        filt_d[i] = 1'b0;
        act_d[i]  = '0;
      end else begin
        if (s2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= debounce_len) begin
          // >= so that shrinking debounce_len mid-count cannot strand a channel.
          filt_d[i] = s2_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
        if (rise_d[i] || fall_d[i]) begin
          act_d[i] = '1;
        end else if (act_q[i] != '0) begin
          act_d[i] = act_q[i] - STRETCH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= '0;
      end
    end else begin
      s1_q   <= internal_in;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      input_act[i] = (act_q[i] != '0);
    end
  end

  assign in_filtered = filt_q;
  assign rise_strb   = rise_q;
  assign fall_strb   = fall_q;

endmodule

// File: tb/tb_ibpl_input_conditioner.sv
// Directed bench for ibpl_input_conditioner with a 15-cycle activity stretch.
module tb_ibpl_input_conditioner;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic [5:0] internal_in;
  logic [5:0] input_enable;
  logic [7:0] debounce_len;
  logic [5:0] in_filtered, rise_strb, fall_strb, input_act;

  ibpl_input_conditioner #(
    .CHANNELS  (6),
    .DEB_W     (8),
    .STRETCH_W (4)
  ) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .internal_in  (internal_in),
    .input_enable (input_enable),
    .debounce_len (debounce_len),
    .in_filtered  (in_filtered),
    .rise_strb    (rise_strb),
    .fall_strb    (fall_strb),
    .input_act    (input_act)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;
  int rise_n, fall_n, rise_e, fall_e, act_n, act_first, act_last;
  logic       seen;
  logic [5:0] others_strb;
  logic       lvl [0:31];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clr_trk();
    rise_n = 0; fall_n = 0; rise_e = -1; fall_e = -1;
    act_n = 0; act_first = -1; act_last = -1;
  endtask

  task automatic trk(input int ch, input int e);
    if (rise_strb[ch]) begin rise_n++; if (rise_e < 0) rise_e = e; end
    if (fall_strb[ch]) begin fall_n++; if (fall_e < 0) fall_e = e; end
    if (input_act[ch]) begin act_n++; if (act_first < 0) act_first = e; act_last = e; end
  endtask

  initial begin
    // 1. Reset values, then every channel rises at edge D+2 = 6.
    rst = 1'b1; internal_in = 6'h3F; input_enable = 6'h3F; debounce_len = 8'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_outputs", {in_filtered, rise_strb, fall_strb, input_act}, 32'h0);
    end
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e < 6) begin
        check("post_rst_quiet", {in_filtered, rise_strb, fall_strb, input_act}, 32'h0);
      end else if (e == 6) begin
        check("post_rst_rise", rise_strb, 32'h3F);
        check("post_rst_filt", in_filtered, 32'h3F);
        check("post_rst_act", input_act, 32'h3F);
      end else begin
        check("post_rst_rise_1cyc", rise_strb, 32'h0);
        check("post_rst_filt_hold", in_filtered, 32'h3F);
      end
    end
    internal_in = 6'h00;
    idle(30);
    check("settle_filt", in_filtered, 32'h0);
    check("settle_act", input_act, 32'h0);

    // 2a. Four-cycle pulse at D=4 is rejected.
    clr_trk(); seen = 1'b0;
    internal_in[0] = 1'b1;
    for (int e = 0; e < 15; e++) begin
      tick(); trk(0, e); seen |= in_filtered[0];
      if (e == 3) internal_in[0] = 1'b0;
    end
    check("glitch4_rise_n", rise_n, 32'd0);
    check("glitch4_fall_n", fall_n, 32'd0);
    check("glitch4_filt", seen, 32'd0);

    // 2b. Five-cycle pulse is accepted; fall lands 6 edges after the low reaches s1.
    clr_trk();
    internal_in[0] = 1'b1;
    for (int e = 0; e < 21; e++) begin
      tick(); trk(0, e);
      if (e == 4) internal_in[0] = 1'b0;
    end
    check("glitch5_rise_n", rise_n, 32'd1);
    check("glitch5_rise_e", rise_e, 32'd6);
    check("glitch5_fall_n", fall_n, 32'd1);
    check("glitch5_fall_e", fall_e, 32'd11);
    idle(20);

    // 3. D=0 passthrough: ch3 toggles every 3 cycles, filter trails s1 by 2 edges.
    debounce_len = 8'd0;
    clr_trk();
    for (int k = 0; k < 32; k++) lvl[k] = 1'b0;
    internal_in[3] = 1'b1; lvl[3] = 1'b1;
    for (int e = 0; e < 22; e++) begin
      tick(); trk(3, e);
      check("pass_filt", in_filtered[3], lvl[e+1]);
      check("pass_rise", rise_strb[3], lvl[e+1] & ~lvl[e]);
      check("pass_fall", fall_strb[3], ~lvl[e+1] & lvl[e]);
      lvl[e+4] = (e < 15 && e % 3 == 2) ? ~lvl[e+3] : lvl[e+3];
      internal_in[3] = lvl[e+4];
    end
    check("pass_rise_n", rise_n, 32'd3);
    check("pass_fall_n", fall_n, 32'd3);
    idle(20);

    // 4. Single edge gives 15 active cycles; retrigger 10 cycles later gives 25.
    clr_trk();
    internal_in[1] = 1'b1;
    for (int e = 0; e < 30; e++) begin tick(); trk(1, e); end
    check("act_single_n", act_n, 32'd15);
    check("act_single_first", act_first, 32'd2);
    check("act_single_last", act_last, 32'd16);
    clr_trk();
    internal_in[1] = 1'b0;
    for (int e = 0; e < 40; e++) begin
      tick(); trk(1, e);
      if (e == 9) internal_in[1] = 1'b1;
    end
    check("act_retrig_fall_e", fall_e, 32'd2);
    check("act_retrig_rise_e", rise_e, 32'd12);
    check("act_retrig_n", act_n, 32'd25);
    check("act_retrig_first", act_first, 32'd2);
    check("act_retrig_last", act_last, 32'd26);

    // 5. Enable gating on ch5 with D=4.
    debounce_len = 8'd4;
    input_enable[5] = 1'b0; internal_in[5] = 1'b1;
    clr_trk(); seen = 1'b0;
    for (int e = 0; e < 10; e++) begin tick(); trk(5, e); seen |= in_filtered[5]; end
    check("dis_rise_n", rise_n, 32'd0);
    check("dis_filt", seen, 32'd0);
    check("dis_act_n", act_n, 32'd0);
    // s2 is already high, so counting starts on the first enabled edge (edge 0).
    input_enable[5] = 1'b1;
    clr_trk();
    for (int e = 0; e < 8; e++) begin tick(); trk(5, e); end
    check("en_rise_n", rise_n, 32'd1);
    check("en_rise_e", rise_e, 32'd4);
    check("en_filt", in_filtered[5], 32'd1);
    input_enable[5] = 1'b0;
    tick();
    check("dis_drop_filt", in_filtered[5], 32'd0);
    check("dis_drop_fall", fall_strb[5], 32'd0);
    check("dis_drop_act", input_act[5], 32'd0);

    // 6. Lower debounce_len mid-count on ch2; other channels must not move.
    check("others_before", in_filtered & 6'h3B, 32'h02);
    debounce_len = 8'd200;
    clr_trk(); others_strb = 6'h00;
    internal_in[2] = 1'b1;
    for (int e = 0; e < 51; e++) begin
      tick(); trk(2, e);
      others_strb |= (rise_strb | fall_strb) & 6'h3B;
      if (e == 49) begin
        check("dlen_filt_before", in_filtered[2], 32'd0);
        debounce_len = 8'd10;
      end
      if (e == 50) begin
        check("dlen_rise", rise_strb[2], 32'd1);
        check("dlen_filt_after", in_filtered[2], 32'd1);
      end
    end
    check("dlen_rise_n", rise_n, 32'd1);
    check("others_strb", others_strb, 32'h0);
    check("others_after", in_filtered & 6'h3B, 32'h02);

    // 7. Reset mid-debounce: nothing on the reset edge or the first edge after.
    debounce_len = 8'd4;
    internal_in[4] = 1'b1;
    idle(3);
    rst = 1'b1;
    tick();
    check("midrst_edge", {in_filtered, rise_strb, fall_strb, input_act}, 32'h0);
    rst = 1'b0;
    tick();
    check("midrst_first", {in_filtered, rise_strb, fall_strb, input_act}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
